// File: rtl/credit_rr_arbiter_pkg.sv
// Shared helpers for the credit round-robin arbiter: grant index width
// calculation and the rotating-priority one-hot pick function.
package credit_arb_pkg;

    // Widest requester vector the pick helper handles; callers zero-pad to this.
    localparam int c_max_reqs = 32;

    // Width of a requester index, never less than one bit.
    function automatic int clog2_min1(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    // One-hot pick of the first valid requester at or after ptr, wrapping at n.
    // Only the low n bits of val are considered; the result is zero when none is valid.
    function automatic logic [c_max_reqs-1:0] rr_pick(
        input logic [c_max_reqs-1:0] val,
        input int unsigned           ptr,
        input int unsigned           n
    );
        logic [c_max_reqs-1:0] pick;
        logic                  found;
        int unsigned           idx;
        pick  = {c_max_reqs{1'b0}};
        found = 1'b0;
        for (int unsigned k = 0; k < c_max_reqs; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end else begin
                    idx = idx;
                end
                if (!found && val[idx]) begin
                    pick[idx] = 1'b1;
                    found     = 1'b1;
                end else begin
                    found = found;
                end
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/credit_rr_arbiter_credit_pool_counter.sv
// Saturating up/down credit counter. inc and dec together leave the count
// unchanged; inc at the maximum and dec at zero are both ignored.
module credit_pool_counter #(
    parameter int p_width     = 4,
    parameter int p_max_value = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               dec,
    output logic [p_width-1:0] count,
    output logic               is_zero,
    output logic               is_max
);

    localparam logic [p_width-1:0] c_max  = p_width'(p_max_value);
    localparam logic [p_width-1:0] c_one  = p_width'(1);
    localparam logic [p_width-1:0] c_zero = p_width'(0);

    logic [p_width-1:0] count_r;
    logic               is_zero_s;
    logic               is_max_s;

    // Status flags decoded from the current count.
    always_comb begin
        is_zero_s = (count_r == c_zero);
        is_max_s  = (count_r == c_max);
    end

    // Count register: starts full, moves by one step, saturates at both ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= c_max;
        end else begin
            case ({inc, dec})
                2'b10: begin
                    if (!is_max_s) begin
                        count_r <= count_r + c_one;
                    end else begin
                        count_r <= count_r;
                    end
                end
                2'b01: begin
                    if (!is_zero_s) begin
                        count_r <= count_r - c_one;
                    end else begin
                        count_r <= count_r;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign count   = count_r;
    assign is_zero = is_zero_s;
    assign is_max  = is_max_s;

endmodule

// File: rtl/credit_rr_arbiter.sv
// Credit-gated round-robin arbiter. A requester is granted in the same cycle
// it presents val, provided at least one credit is held; each grant spends a
// credit and credits come back one per cycle from the downstream buffer.
module credit_rr_arbiter
    import credit_arb_pkg::*;
#(
    parameter int p_num_reqs     = 4,
    parameter int p_credit_nbits = 4,
    parameter int p_num_credits  = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [p_num_reqs-1:0]                req_val,
    output logic [p_num_reqs-1:0]                req_rdy,
    output logic [clog2_min1(p_num_reqs)-1:0]    grant_id,
    output logic                                 grant_val,
    input  logic                                 credit_return,
    output logic [p_credit_nbits-1:0]            credits,
    output logic                                 credits_empty,
    output logic                                 credits_full,
    output logic                                 overflow_err
);

    localparam int                c_id_w    = clog2_min1(p_num_reqs);
    localparam logic [c_id_w-1:0] c_last_id = c_id_w'(p_num_reqs - 1);
    localparam logic [c_id_w-1:0] c_id_zero = c_id_w'(0);
    localparam logic [c_id_w-1:0] c_id_one  = c_id_w'(1);

    logic [c_id_w-1:0]         prio_ptr_r;
    logic [c_id_w-1:0]         prio_ptr_next_s;
    logic                      overflow_err_r;
    logic [c_max_reqs-1:0]     val_pad_s;
    logic [c_max_reqs-1:0]     pick_pad_s;
    logic [p_num_reqs-1:0]     rdy_s;
    logic [c_id_w-1:0]         grant_id_s;
    logic                      fire_s;
    logic [p_credit_nbits-1:0] credits_s;
    logic                      is_zero_s;
    logic                      is_max_s;

    // Rotating-priority pick; withheld with no credits or while reset is held,
    // and deliberately blind to credit_return so a returned credit is usable
    // only from the next cycle.
    always_comb begin
        val_pad_s                 = {c_max_reqs{1'b0}};
        val_pad_s[p_num_reqs-1:0] = req_val;
        if (is_zero_s || reset) begin
            pick_pad_s = {c_max_reqs{1'b0}};
        end else begin
            pick_pad_s = rr_pick(val_pad_s, 32'(prio_ptr_r), 32'(p_num_reqs));
        end
        rdy_s  = pick_pad_s[p_num_reqs-1:0];
        fire_s = |pick_pad_s;
    end

    // Encode the one-hot grant into an index (zero when nothing is granted).
    always_comb begin
        grant_id_s = c_id_zero;
        for (int i = 0; i < p_num_reqs; i++) begin
            grant_id_s = grant_id_s | (rdy_s[i] ? c_id_w'(i) : c_id_zero);
        end
    end

    // Next priority pointer: the requester after the one just granted, wrapping.
    always_comb begin
        if (grant_id_s == c_last_id) begin
            prio_ptr_next_s = c_id_zero;
        end else begin
            prio_ptr_next_s = grant_id_s + c_id_one;
        end
    end

    // Priority pointer advances only when a grant fires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_ptr_r <= c_id_zero;
        end else if (fire_s) begin
            prio_ptr_r <= prio_ptr_next_s;
        end else begin
            prio_ptr_r <= prio_ptr_r;
        end
    end

    // Sticky flag for a credit returned while the pool is already full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_err_r <= 1'b0;
        end else if (credit_return && !fire_s && is_max_s) begin
            overflow_err_r <= 1'b1;
        end else begin
            overflow_err_r <= overflow_err_r;
        end
    end

    credit_pool_counter #(
        .p_width     (p_credit_nbits),
        .p_max_value (p_num_credits)
    ) u_pool (
        .clk     (clk),
        .reset   (reset),
        .inc     (credit_return),
        .dec     (fire_s),
        .count   (credits_s),
        .is_zero (is_zero_s),
        .is_max  (is_max_s)
    );

    assign req_rdy       = rdy_s;
    assign grant_id      = grant_id_s;
    assign grant_val     = fire_s;
    assign credits       = credits_s;
    assign credits_empty = is_zero_s;
    assign credits_full  = is_max_s;
    assign overflow_err  = overflow_err_r;

endmodule

// File: tb/tb_credit_rr_arbiter.sv
// Directed bench for credit_rr_arbiter with four requesters and three credits.
module tb_credit_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req_val;
    logic [3:0] req_rdy;
    logic [1:0] grant_id;
    logic       grant_val;
    logic       credit_return;
    logic [3:0] credits;
    logic       credits_empty;
    logic       credits_full;
    logic       overflow_err;

    int checks;
    int errors;

    credit_rr_arbiter #(
        .p_num_reqs     (4),
        .p_credit_nbits (4),
        .p_num_credits  (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_val       (req_val),
        .req_rdy       (req_rdy),
        .grant_id      (grant_id),
        .grant_val     (grant_val),
        .credit_return (credit_return),
        .credits       (credits),
        .credits_empty (credits_empty),
        .credits_full  (credits_full),
        .overflow_err  (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        req_val       = 4'b0000;
        credit_return = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // 1: reset state
        chk("rst_credits", 32'(credits), 32'd3);
        chk("rst_full", 32'(credits_full), 32'd1);
        chk("rst_empty", 32'(credits_empty), 32'd0);
        chk("rst_rdy", 32'(req_rdy), 32'h0);
        chk("rst_gval", 32'(grant_val), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_ovf", 32'(overflow_err), 32'd0);

        // 2: all requesting, credits drain 3,2,1,0 with grants 0,1,2
        req_val = 4'b1111;
        #1;
        chk("t2_rdy0", 32'(req_rdy), 32'h1);
        chk("t2_gid0", 32'(grant_id), 32'd0);
        tick();
        chk("t2_cred2", 32'(credits), 32'd2);
        chk("t2_rdy1", 32'(req_rdy), 32'h2);
        chk("t2_gid1", 32'(grant_id), 32'd1);
        tick();
        chk("t2_cred1", 32'(credits), 32'd1);
        chk("t2_rdy2", 32'(req_rdy), 32'h4);
        chk("t2_gid2", 32'(grant_id), 32'd2);
        tick();
        chk("t2_cred0", 32'(credits), 32'd0);
        chk("t2_empty", 32'(credits_empty), 32'd1);
        chk("t2_rdy_none", 32'(req_rdy), 32'h0);
        chk("t2_gval_none", 32'(grant_val), 32'd0);

        // 3: returned credit is not bypassed; next cycle grant goes to 3, then 0
        credit_return = 1'b1;
        #1;
        chk("t3_no_bypass", 32'(req_rdy), 32'h0);
        tick();
        credit_return = 1'b0;
        chk("t3_cred1", 32'(credits), 32'd1);
        chk("t3_rdy3", 32'(req_rdy), 32'h8);
        chk("t3_gid3", 32'(grant_id), 32'd3);
        tick();
        chk("t3_cred0", 32'(credits), 32'd0);
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        chk("t3_rdy_wrap", 32'(req_rdy), 32'h1);
        chk("t3_gid_wrap", 32'(grant_id), 32'd0);
        tick();
        chk("t3_cred0b", 32'(credits), 32'd0);

        // 4: credits=1, grant and return in the same cycle keep credits at 1
        req_val       = 4'b0000;
        credit_return = 1'b1;
        tick();
        chk("t4_cred1", 32'(credits), 32'd1);
        req_val = 4'b0010;
        #1;
        chk("t4_rdy1", 32'(req_rdy), 32'h2);
        tick();
        chk("t4_cred_hold", 32'(credits), 32'd1);
        req_val = 4'b0000;
        tick();
        tick();
        credit_return = 1'b0;
        chk("t5_cred3", 32'(credits), 32'd3);
        chk("t5_full", 32'(credits_full), 32'd1);
        chk("t5_ovf_pre", 32'(overflow_err), 32'd0);

        // 5: return while full saturates and sets the sticky error
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        chk("t5_cred_sat", 32'(credits), 32'd3);
        chk("t5_ovf_set", 32'(overflow_err), 32'd1);
        req_val = 4'b0001;
        tick();
        req_val = 4'b0000;
        chk("t5_cred2", 32'(credits), 32'd2);
        chk("t5_ovf_sticky", 32'(overflow_err), 32'd1);
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        chk("t5_cred_back", 32'(credits), 32'd3);
        chk("t5_ovf_sticky2", 32'(overflow_err), 32'd1);

        // 6: reach credits=1, ptr=2, then reset mid-stream
        req_val = 4'b0010;
        tick();
        tick();
        chk("t6_cred1", 32'(credits), 32'd1);
        req_val = 4'b1111;
        #1;
        chk("t6_rdy_ptr2", 32'(req_rdy), 32'h4);
        reset = 1'b1;
        #1;
        chk("t6_rst_rdy", 32'(req_rdy), 32'h0);
        chk("t6_rst_cred", 32'(credits), 32'd3);
        chk("t6_rst_full", 32'(credits_full), 32'd1);
        chk("t6_rst_ovf", 32'(overflow_err), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("t6_post_rdy", 32'(req_rdy), 32'h1);
        chk("t6_post_gid", 32'(grant_id), 32'd0);
        tick();
        chk("t6_post_cred", 32'(credits), 32'd2);
        chk("t6_post_rdy1", 32'(req_rdy), 32'h2);

        req_val = 4'b0000;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
